if_id_hazard_ctrl: RTL and testbench

Pipeline control unit that sequences the IF/ID pipeline register and the PC.
- Generates PC write-enable, IF/ID write-enable and flush, and ID/EX flush from three sources: instruction-cache hit status, load-use hazards and taken branches resolved in EX.
- Tracks outstanding instruction-cache misses across branch redirects.
- Keeps saturating stall and flush performance counters.
- Sits between the fetch stage, the IF/ID register and the EX branch unit.

---
 rtl/if_id_hazard_ctrl_pkg.sv | 34 +++
 rtl/hazard_perf_counter.sv | 35 +++
 rtl/if_id_hazard_ctrl.sv | 167 ++++++++++++++++
 tb/tb_if_id_hazard_ctrl.sv | 215 +++++++++++++++++++++
 4 files changed

// File: rtl/if_id_hazard_ctrl_pkg.sv
// Shared definitions for the IF/ID hazard control slice.
// Holds the controller state encoding, the NOP word loaded on an IF/ID
// flush, and the load-use hazard detect helper.
package if_id_hazard_ctrl_pkg;

  // Controller states; encoding 2'd3 is unused and recovers to RUN.
  typedef enum logic [1:0] {
    ST_RUN          = 2'd0,
    ST_MISS         = 2'd1,
    ST_MISS_DISCARD = 2'd2
  } state_e;

  // addi x0, x0, 0 -- the word the IF/ID register loads when flushed.
  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

  // A load in EX whose destination feeds the instruction in ID. x0 never
  // creates a dependency, and rs2 only matters when ID actually reads it.
  function automatic logic load_use_hazard(
    input logic       ex_mem_read,
    input logic [4:0] ex_rd,
    input logic [4:0] id_rs1,
    input logic [4:0] id_rs2,
    input logic       id_uses_rs2
  );
    logic rd_nz;
    logic hit_rs1;
    logic hit_rs2;
    rd_nz   = (ex_rd != 5'd0);
    hit_rs1 = (ex_rd == id_rs1);
    hit_rs2 = id_uses_rs2 && (ex_rd == id_rs2);
    return ex_mem_read && rd_nz && (hit_rs1 || hit_rs2);
  endfunction

endpackage

// File: rtl/hazard_perf_counter.sv
// Saturating performance counter with synchronous clear.
// Latency: count visible the cycle after an increment.
// Backpressure: none; holds at all-ones instead of wrapping.
module hazard_perf_counter #(
  parameter int W = 32
) (
  input  logic         clk_i,
  input  logic         clr_i,
  input  logic         inc_i,
  output logic [W-1:0] cnt_o
);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  // Next count: bump on increment unless already saturated.
  always_comb begin
    cnt_d = cnt_q;
    if (inc_i && (cnt_q != {W{1'b1}})) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  // Count register; clear has priority over increment.
  always_ff @(posedge clk_i) begin
    if (clr_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt_o = cnt_q;

endmodule

// File: rtl/if_id_hazard_ctrl.sv
// IF/ID and PC sequencing from icache hit, load-use hazards and EX redirects.
// Latency: enables/flushes are combinational from state and inputs.
// Backpressure: stalls PC on load-use or miss; branch > load-use > miss.
module if_id_hazard_ctrl #(
  parameter int XLEN         = 32,
  parameter int MISS_TIMEOUT = 64,
  parameter int TO_W         = 7
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            icache_hit,
  input  logic [4:0]      id_rs1,
  input  logic [4:0]      id_rs2,
  input  logic            id_uses_rs2,
  input  logic [4:0]      ex_rd,
  input  logic            ex_mem_read,
  input  logic            ex_branch_taken,
  output logic            pc_write,
  output logic            if_id_write,
  output logic            if_id_flush,
  output logic            id_ex_flush,
  output logic            miss_err,
  output logic [XLEN-1:0] stall_cnt,
  output logic [XLEN-1:0] flush_cnt
);

  import if_id_hazard_ctrl_pkg::*;

  localparam logic [TO_W-1:0] TIMEOUT_VAL = TO_W'(MISS_TIMEOUT);

  state_e          state_q;
  state_e          state_d;
  logic [TO_W-1:0] wait_cnt_q;
  logic [TO_W-1:0] wait_cnt_d;
  logic            miss_err_q;
  logic            miss_err_d;
  logic            lu;
  logic            flush_inc;
  logic            stall_inc;
  state_e          state_nxt;

  assign lu = load_use_hazard(ex_mem_read, ex_rd, id_rs1, id_rs2, id_uses_rs2);

  // Per-state output decode and raw next state, branch first, then
  // load-use, then fetch miss.
  always_comb begin
    pc_write    = 1'b1;
    if_id_write = 1'b1;
    if_id_flush = 1'b0;
    id_ex_flush = 1'b0;
    flush_inc   = 1'b0;
    state_nxt   = state_q;
    case (state_q)
      ST_RUN: begin
        if (ex_branch_taken) begin
          if_id_flush = 1'b1;
          id_ex_flush = 1'b1;
          flush_inc   = 1'b1;
          // A redirect that also misses leaves the wrong-path fetch in flight.
          state_nxt   = icache_hit ? ST_RUN : ST_MISS_DISCARD;
        end else if (lu) begin
          pc_write    = 1'b0;
          if_id_write = 1'b0;
          id_ex_flush = 1'b1;
        end else if (!icache_hit) begin
          pc_write    = 1'b0;
          if_id_flush = 1'b1;
          state_nxt   = ST_MISS;
        end
      end
      ST_MISS: begin
        if (ex_branch_taken) begin
          if_id_flush = 1'b1;
          id_ex_flush = 1'b1;
          flush_inc   = 1'b1;
          state_nxt   = ST_MISS_DISCARD;
        end else if (lu) begin
          pc_write    = 1'b0;
          if_id_write = 1'b0;
          id_ex_flush = 1'b1;
        end else if (!icache_hit) begin
          pc_write    = 1'b0;
          if_id_flush = 1'b1;
        end else begin
          state_nxt   = ST_RUN;
        end
      end
      ST_MISS_DISCARD: begin
        if (ex_branch_taken) begin
          if_id_flush = 1'b1;
          id_ex_flush = 1'b1;
          flush_inc   = 1'b1;
        end else if (lu) begin
          pc_write    = 1'b0;
          if_id_write = 1'b0;
          id_ex_flush = 1'b1;
        end else if (!icache_hit) begin
          pc_write    = 1'b0;
          if_id_flush = 1'b1;
        end else begin
          // Stale word arrives: drop it, and let the redirected fetch issue.
          if_id_flush = 1'b1;
          state_nxt   = ST_RUN;
        end
      end
      default: begin
        state_nxt = ST_RUN;
      end
    endcase

    // Reset holds the pipeline frozen and bubbled regardless of state.
    if (rst) begin
      pc_write    = 1'b0;
      if_id_write = 1'b0;
      if_id_flush = 1'b1;
      id_ex_flush = 1'b1;
      flush_inc   = 1'b0;
    end
  end

  // Miss-wait tracking: restart on entry (or on a fresh redirect), count
  // while waiting, and bail out to RUN with a sticky error on timeout.
  always_comb begin
    state_d    = state_nxt;
    wait_cnt_d = '0;
    miss_err_d = miss_err_q;
    if ((state_nxt != ST_RUN) && (state_nxt == state_q) && !ex_branch_taken) begin
      wait_cnt_d = wait_cnt_q + 1'b1;
      if (wait_cnt_d == TIMEOUT_VAL) begin
        state_d    = ST_RUN;
        wait_cnt_d = '0;
        miss_err_d = 1'b1;
      end
    end
  end

  // State, wait counter and error flag registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_RUN;
      wait_cnt_q <= '0;
      miss_err_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      wait_cnt_q <= wait_cnt_d;
      miss_err_q <= miss_err_d;
    end
  end

  assign miss_err  = miss_err_q;
  assign stall_inc = !pc_write;

  hazard_perf_counter #(.W(XLEN)) u_stall_cnt (
    .clk_i (clk),
    .clr_i (rst),
    .inc_i (stall_inc),
    .cnt_o (stall_cnt)
  );

  hazard_perf_counter #(.W(XLEN)) u_flush_cnt (
    .clk_i (clk),
    .clr_i (rst),
    .inc_i (flush_inc),
    .cnt_o (flush_cnt)
  );

endmodule

// File: tb/tb_if_id_hazard_ctrl.sv
// Scoreboard bench for if_id_hazard_ctrl.
// Expected outputs queued at drive time, compared at the falling edge.
// Narrow counters so saturation is reachable within the timeout run.
module tb_if_id_hazard_ctrl;

  localparam int XLEN = 6;
  localparam int MISS_TIMEOUT = 64;
  localparam int TO_W = 7;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic icache_hit = 1'b1;
  logic [4:0] id_rs1 = 5'd1;
  logic [4:0] id_rs2 = 5'd2;
  logic id_uses_rs2 = 1'b0;
  logic [4:0] ex_rd = 5'd3;
  logic ex_mem_read = 1'b0;
  logic ex_branch_taken = 1'b0;
  logic pc_write, if_id_write, if_id_flush, id_ex_flush, miss_err;
  logic [XLEN-1:0] stall_cnt, flush_cnt;

  if_id_hazard_ctrl #(.XLEN(XLEN), .MISS_TIMEOUT(MISS_TIMEOUT), .TO_W(TO_W)) dut (
    .clk(clk), .rst(rst), .icache_hit(icache_hit),
    .id_rs1(id_rs1), .id_rs2(id_rs2), .id_uses_rs2(id_uses_rs2),
    .ex_rd(ex_rd), .ex_mem_read(ex_mem_read), .ex_branch_taken(ex_branch_taken),
    .pc_write(pc_write), .if_id_write(if_id_write), .if_id_flush(if_id_flush),
    .id_ex_flush(id_ex_flush), .miss_err(miss_err),
    .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic pw, iw, f1, f2, err;
    logic [1:0] st;
    logic [XLEN-1:0] stall, flush;
    bit known;
  } exp_t;

  exp_t sb[$];

  int n_chk = 0;
  int n_fail = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // Reference model state.
  logic [1:0] m_st = 2'd0;
  int m_wait = 0;
  logic m_err = 1'b0;
  logic [XLEN-1:0] m_stall = '0;
  logic [XLEN-1:0] m_flush = '0;
  bit m_known = 1'b0;

  // One cycle: drive inputs, queue expectation, advance the model.
  task automatic step(input logic r, input logic hit, input logic [4:0] rs1,
                      input logic [4:0] rs2, input logic u2, input logic [4:0] rd,
                      input logic mr, input logic br);
    exp_t e;
    logic lu, pw, iw, f1, f2;
    logic [1:0] nst;
    @(posedge clk); #1;
    rst = r; icache_hit = hit; id_rs1 = rs1; id_rs2 = rs2; id_uses_rs2 = u2;
    ex_rd = rd; ex_mem_read = mr; ex_branch_taken = br;
    lu = mr && (rd != 0) && ((rd == rs1) || (u2 && (rd == rs2)));
    nst = m_st;
    if (br)       begin pw = 1; iw = 1; f1 = 1; f2 = 1; nst = (m_st == 0 && hit) ? 2'd0 : 2'd2; end
    else if (lu)  begin pw = 0; iw = 0; f1 = 0; f2 = 1; end
    else if (!hit) begin pw = 0; iw = 1; f1 = 1; f2 = 0; if (m_st == 0) nst = 2'd1; end
    else if (m_st == 2) begin pw = 1; iw = 1; f1 = 1; f2 = 0; nst = 2'd0; end
    else begin pw = 1; iw = 1; f1 = 0; f2 = 0; nst = 2'd0; end
    if (r) begin pw = 0; iw = 0; f1 = 1; f2 = 1; end
    e.pw = pw; e.iw = iw; e.f1 = f1; e.f2 = f2; e.err = m_err; e.st = m_st;
    e.stall = m_stall; e.flush = m_flush; e.known = m_known;
    sb.push_back(e);
    if (r) begin
      m_st = 0; m_wait = 0; m_err = 0; m_stall = '0; m_flush = '0;
    end else begin
      if (!pw && m_stall != {XLEN{1'b1}}) m_stall = m_stall + 1'b1;
      if (br && m_flush != {XLEN{1'b1}}) m_flush = m_flush + 1'b1;
      if (nst == 0) m_wait = 0;
      else if (nst != m_st || br) m_wait = 0;
      else begin
        m_wait = m_wait + 1;
        if (m_wait == MISS_TIMEOUT) begin nst = 0; m_wait = 0; m_err = 1; end
      end
      m_st = nst;
    end
    m_known = 1'b1;
  endtask

  task automatic idle();
    step(0, 1, 5'd1, 5'd2, 0, 5'd3, 0, 0);
  endtask

  task automatic miss_cyc();
    step(0, 0, 5'd1, 5'd2, 0, 5'd3, 0, 0);
  endtask

  // Scoreboard compare at the falling edge.
  always @(negedge clk) begin : mon
    exp_t e;
    if (sb.size() > 0) begin
      e = sb.pop_front();
      chk("pc_write", pc_write, e.pw);
      chk("if_id_write", if_id_write, e.iw);
      chk("if_id_flush", if_id_flush, e.f1);
      chk("id_ex_flush", id_ex_flush, e.f2);
      if (e.known) begin
        chk("state", dut.state_q, e.st);
        chk("miss_err", miss_err, e.err);
        chk("stall_cnt", stall_cnt, e.stall);
        chk("flush_cnt", flush_cnt, e.flush);
      end
    end
  end

  initial begin
    // Reset
    step(1, 1, 5'd1, 5'd2, 0, 5'd3, 0, 0);
    step(1, 1, 5'd1, 5'd2, 0, 5'd3, 0, 0);
    idle();
    chk("rst_stall", stall_cnt, 0);
    chk("rst_flush", flush_cnt, 0);
    chk("rst_err", miss_err, 0);
    idle();

    // Load-use on rs1: one bubble only
    step(0, 1, 5'd5, 5'd0, 0, 5'd5, 1, 0);
    #1 chk("lu_pw", pc_write, 0);
    idle();
    #1 chk("lu_once_pw", pc_write, 1);
    chk("lu_stall", stall_cnt, 1);

    // x0 and rs2 filtering
    step(0, 1, 5'd0, 5'd4, 0, 5'd0, 1, 0);
    #1 chk("x0_pw", pc_write, 1);
    step(0, 1, 5'd1, 5'd7, 0, 5'd7, 1, 0);
    #1 chk("rs2_unused_pw", pc_write, 1);
    step(0, 1, 5'd1, 5'd7, 1, 5'd7, 1, 0);
    #1 chk("rs2_used_pw", pc_write, 0);
    idle();
    chk("rs2_stall", stall_cnt, 2);

    // Three-cycle miss
    for (int i = 0; i < 3; i++) miss_cyc();
    idle();
    chk("miss_stall", stall_cnt, 5);
    chk("miss_state", dut.state_q, 1);
    idle();
    chk("miss_back_run", dut.state_q, 0);

    // Branch during miss, hit at cycle 5
    miss_cyc();
    step(0, 0, 5'd1, 5'd2, 0, 5'd3, 0, 1);
    miss_cyc();
    miss_cyc();
    idle();
    #1 chk("bm_pw", pc_write, 1);
    chk("bm_flush_word", if_id_flush, 1);
    idle();
    chk("bm_flush_cnt", flush_cnt, 1);
    chk("bm_state", dut.state_q, 0);
    chk("bm_stall", stall_cnt, 8);

    // Branch and load-use together
    step(0, 1, 5'd5, 5'd0, 0, 5'd5, 1, 1);
    #1 chk("blu_pw", pc_write, 1);
    chk("blu_idex", id_ex_flush, 1);
    chk("blu_ifid", if_id_flush, 1);
    idle();
    chk("blu_stall", stall_cnt, 8);
    chk("blu_flush", flush_cnt, 2);

    // Redirect that misses, second redirect while discarding
    step(0, 0, 5'd1, 5'd2, 0, 5'd3, 0, 1);
    miss_cyc();
    step(0, 0, 5'd1, 5'd2, 0, 5'd3, 0, 1);
    idle();
    idle();
    chk("disc_flush", flush_cnt, 4);
    chk("disc_stall", stall_cnt, 9);

    // Timeout: counter saturation along the way
    for (int i = 0; i < MISS_TIMEOUT + 1; i++) miss_cyc();
    chk("to_err_early", miss_err, 0);
    chk("to_state_early", dut.state_q, 1);
    idle();
    chk("to_err", miss_err, 1);
    chk("to_state", dut.state_q, 0);
    chk("to_stall_sat", stall_cnt, 63);
    idle();
    chk("to_err_sticky", miss_err, 1);

    // Reset clears everything
    step(1, 1, 5'd1, 5'd2, 0, 5'd3, 0, 0);
    idle();
    chk("rst2_err", miss_err, 0);
    chk("rst2_stall", stall_cnt, 0);
    chk("rst2_flush", flush_cnt, 0);
    idle();

    @(negedge clk); #1;
    chk("sb_drained", sb.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
